// File: rtl/seq_pattern_detector.sv
// Multi-channel Mealy serial pattern detector over a shared bit history.
// Define SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN to build per-channel saturating match counters.
module seq_pattern_detector #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SEL_W   = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i,
  input  logic               i_valid,
  input  logic               pat_we,
  input  logic [SEL_W-1:0]   pat_sel,
  input  logic [PAT_LEN-1:0] pat_data,
  input  logic               pat_en,
  input  logic               pat_ovl,
  input  logic               cnt_clr,
  output logic [NUM_PAT-1:0] o,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam int unsigned      FillW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0]              hist_q, hist_d;
  logic [PAT_LEN-1:0]              win;
  logic [NUM_PAT-1:0][PAT_LEN-1:0] pat_q, pat_d;
  logic [NUM_PAT-1:0][FillW-1:0]   fill_q, fill_d;
  logic [NUM_PAT-1:0]              en_q, en_d;
  logic [NUM_PAT-1:0]              ovl_q, ovl_d;
  logic [NUM_PAT-1:0]              match;

  // Window seen this cycle: stored history plus the bit currently on the wire.
  assign win = {hist_q, i};

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      match[k] = i_valid & en_q[k] & (fill_q[k] == FillMax) & (win == pat_q[k]);
    end
  end

  assign o = match;

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    fill_d = fill_q;
    en_d   = en_q;
    ovl_d  = ovl_q;
    if (i_valid) begin
      hist_d = win[PAT_LEN-2:0];
    end
    for (int k = 0; k < NUM_PAT; k++) begin
      if (i_valid) begin
        if (!ovl_q[k] && match[k]) begin
          fill_d[k] = '0;
        end else if (fill_q[k] != FillMax) begin
          fill_d[k] = fill_q[k] + FillW'(1);
        end
      end
      // A configuration write restarts the channel, overriding any fill update.
      if (pat_we && (pat_sel == SEL_W'(k))) begin
        pat_d[k]  = pat_data;
        en_d[k]   = pat_en;
        ovl_d[k]  = pat_ovl;
        fill_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      pat_q  <= '0;
      fill_q <= '0;
      en_q   <= '0;
      ovl_q  <= '0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      en_q   <= en_d;
      ovl_q  <= ovl_d;
    end
  end

`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
  logic [NUM_PAT-1:0][CNT_W-1:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    for (int k = 0; k < NUM_PAT; k++) begin
      if (cnt_clr) begin
        mcnt_d[k] = '0;
      end else if (match[k] && (mcnt_q[k] != {CNT_W{1'b1}})) begin
        mcnt_d[k] = mcnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    cnt_out = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      if (pat_sel == SEL_W'(k)) begin
        cnt_out = mcnt_q[k];
      end
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (PAT_LEN=3, NUM_PAT=2, CNT_W=8).
// Counter expectations follow SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN.
module tb_seq_pattern_detector;

  logic       clock;
  logic       reset_n;
  logic       i;
  logic       i_valid;
  logic       pat_we;
  logic [0:0] pat_sel;
  logic [2:0] pat_data;
  logic       pat_en;
  logic       pat_ovl;
  logic       cnt_clr;
  logic [1:0] o;
  logic [7:0] cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  seq_pattern_detector #(
    .PAT_LEN(3),
    .NUM_PAT(2),
    .CNT_W  (8),
    .SEL_W  (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i       (i),
    .i_valid (i_valid),
    .pat_we  (pat_we),
    .pat_sel (pat_sel),
    .pat_data(pat_data),
    .pat_en  (pat_en),
    .pat_ovl (pat_ovl),
    .cnt_clr (cnt_clr),
    .o       (o),
    .cnt_out (cnt_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int v);
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
    return 8'(v);
`else
    return 8'(v * 0);
`endif
  endfunction

  // One cycle: drive a bit (valid or idle) after the falling edge, then check o.
  task automatic send(input logic b, input logic v, input logic [1:0] exp, input string tag);
    @(negedge clock);
    i       = b;
    i_valid = v;
    pat_we  = 1'b0;
    cnt_clr = 1'b0;
    #1 check(tag, 32'(o), 32'(exp));
  endtask

  task automatic cfg(input logic sel, input logic [2:0] pat, input logic en, input logic ovl);
    @(negedge clock);
    i_valid  = 1'b0;
    cnt_clr  = 1'b0;
    pat_we   = 1'b1;
    pat_sel  = sel;
    pat_data = pat;
    pat_en   = en;
    pat_ovl  = ovl;
  endtask

  task automatic check_cnt(input logic sel, input int v, input string tag);
    @(negedge clock);
    i_valid = 1'b0;
    pat_we  = 1'b0;
    cnt_clr = 1'b0;
    pat_sel = sel;
    #1 check({tag, "_o"}, 32'(o), 32'd0);
    check(tag, 32'(cnt_out), 32'(cnt_exp(v)));
  endtask

  logic [9:0] s1;
  logic [1:0] e1 [10];
  logic [6:0] s2;
  logic [1:0] e_nov [7];
  logic [1:0] e_ovl [7];

  initial begin
    s1    = 10'b0110101011;
    e1    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0};
    s2    = 7'b1010101;
    e_nov = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    e_ovl = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

    reset_n  = 1'b0;
    i        = 1'b0;
    i_valid  = 1'b0;
    pat_we   = 1'b0;
    pat_sel  = 1'b0;
    pat_data = '0;
    pat_en   = 1'b0;
    pat_ovl  = 1'b0;
    cnt_clr  = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Unconfigured channels never match.
    send(1'b0, 1'b1, 2'd0, "rst_o_a");
    send(1'b1, 1'b1, 2'd0, "rst_o_b");
    send(1'b1, 1'b1, 2'd0, "rst_o_c");
    check_cnt(1'b0, 0, "rst_cnt");

    // Both channels overlapping over 0110101011.
    cfg(1'b0, 3'b101, 1'b1, 1'b1);
    cfg(1'b1, 3'b010, 1'b1, 1'b1);
    for (int t = 0; t < 10; t++) send(s1[9-t], 1'b1, e1[t], $sformatf("ovl2_t%0d", t));
    check_cnt(1'b0, 3, "ovl2_cnt0");
    check_cnt(1'b1, 2, "ovl2_cnt1");

    // Non-overlapping vs overlapping on 1010101, ch1 disabled.
    cfg(1'b1, 3'b010, 1'b0, 1'b1);
    cfg(1'b0, 3'b101, 1'b1, 1'b0);
    for (int t = 0; t < 7; t++) send(s2[6-t], 1'b1, e_nov[t], $sformatf("nov_t%0d", t));
    cfg(1'b0, 3'b101, 1'b1, 1'b1);
    for (int t = 0; t < 7; t++) send(s2[6-t], 1'b1, e_ovl[t], $sformatf("ovl_t%0d", t));

    // Same non-overlapping run with three idle cycles between bits.
    cfg(1'b0, 3'b101, 1'b1, 1'b0);
    for (int t = 0; t < 7; t++) begin
      send(s2[6-t], 1'b1, e_nov[t], $sformatf("gap_t%0d", t));
      for (int g = 0; g < 3; g++) send(1'b1, 1'b0, 2'd0, $sformatf("gap_idle%0d_%0d", t, g));
    end

    // Reset in mid-stream drops o asynchronously and discards all state.
    cfg(1'b1, 3'b010, 1'b1, 1'b1);
    cfg(1'b0, 3'b101, 1'b1, 1'b1);
    send(1'b1, 1'b1, 2'd0, "rs_t0");
    send(1'b0, 1'b1, 2'd0, "rs_t1");
    send(1'b1, 1'b1, 2'd1, "rs_t2");
    send(1'b0, 1'b1, 2'd2, "rs_t3");
    #1 reset_n = 1'b0;
    #1 check("rs_async", 32'(o), 32'd0);
    @(negedge clock);
    i = 1'b1;
    #1 check("rs_held", 32'(o), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    send(1'b1, 1'b1, 2'd0, "rs_post0");
    send(1'b0, 1'b1, 2'd0, "rs_post1");
    send(1'b1, 1'b1, 2'd0, "rs_post2");
    cfg(1'b0, 3'b101, 1'b1, 1'b1);
    cfg(1'b1, 3'b010, 1'b1, 1'b1);
    send(1'b0, 1'b1, 2'd0, "rs_new0");
    send(1'b1, 1'b1, 2'd0, "rs_new1");
    send(1'b0, 1'b1, 2'd2, "rs_new2");
    send(1'b1, 1'b1, 2'd1, "rs_new3");

    // Reprogram ch0 to 111 in the same cycle as a 101 match.
    send(1'b0, 1'b1, 2'd2, "rp_pre");
    @(negedge clock);
    i        = 1'b1;
    i_valid  = 1'b1;
    pat_we   = 1'b1;
    pat_sel  = 1'b0;
    pat_data = 3'b111;
    pat_en   = 1'b1;
    pat_ovl  = 1'b1;
    #1 check("rp_same", 32'(o), 32'd1);
    send(1'b1, 1'b1, 2'd0, "rp_f0");
    send(1'b1, 1'b1, 2'd0, "rp_f1");
    send(1'b1, 1'b1, 2'd1, "rp_f2");

    // Counter saturation and clear priority.
    @(negedge clock);
    i_valid = 1'b0;
    cnt_clr = 1'b1;
    check_cnt(1'b0, 0, "sat_clr");
    for (int n = 0; n < 254; n++) send(1'b1, 1'b1, 2'd1, "sat_run");
    check_cnt(1'b0, 254, "sat_254");
    send(1'b1, 1'b1, 2'd1, "sat_run");
    check_cnt(1'b0, 255, "sat_255");
    for (int n = 0; n < 45; n++) send(1'b1, 1'b1, 2'd1, "sat_run");
    check_cnt(1'b0, 255, "sat_hold");
    check_cnt(1'b1, 0, "sat_ch1");
    @(negedge clock);
    i       = 1'b1;
    i_valid = 1'b1;
    pat_we  = 1'b0;
    cnt_clr = 1'b1;
    #1 check("clr_match_o", 32'(o), 32'd1);
    check_cnt(1'b0, 0, "clr_prio");
    send(1'b1, 1'b1, 2'd1, "clr_after");
    check_cnt(1'b0, 1, "clr_inc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
